// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit
package lsu_pkg;
   localparam int XLEN = 32;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_ILL} size_e;
   typedef enum logic [2:0] {IDLE, LD_ADDR, LD_DATA, ST_WR, RMW_RD, RMW_WR, RESP} state_e;
   function automatic logic is_misaligned(size_e size, logic [1:0] off);
      return size == SZ_ILL || (size == SZ_H && off[0]) || (size == SZ_W && off != 2'b00);
   endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load lane extract/extend and sub-word store merge into the old word
module lsu_align
   import lsu_pkg::*;
(
   input  logic [XLEN-1:0] word_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [1:0]      off_i,
   input  size_e           size_i,
   input  logic            unsigned_i,
   output logic [XLEN-1:0] rdata_o,
   output logic [XLEN-1:0] merged_o
);
   logic [4:0]      sh;
   logic [15:0]     lane;
   logic [XLEN-1:0] mask;
   always_comb begin
      sh       = {off_i, 3'b000};
      lane     = 16'(word_i >> sh);
      mask     = (size_i == SZ_B) ? 32'h0000_00ff << sh : (size_i == SZ_H) ? 32'h0000_ffff << sh : '1;
      rdata_o  = (size_i == SZ_B) ? {{24{~unsigned_i & lane[7]}}, lane[7:0]} :
                 (size_i == SZ_H) ? {{16{~unsigned_i & lane[15]}}, lane[15:0]} : word_i;
      merged_o = (word_i & ~mask) | ((wdata_i << sh) & mask);
   end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: byte-addressed load/store FSM driving a word-wide synchronous-read memory
module lsu_mem_ctrl #(
   parameter int MEM_AW = 10,
   parameter int XLEN   = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [31:0]       req_addr_i,
   input  logic [XLEN-1:0]   req_wdata_i,
   output logic              resp_valid_o,
   output logic [XLEN-1:0]   resp_rdata_o,
   output logic              resp_err_o,
   output logic              mem_we_o,
   output logic [MEM_AW-1:0] mem_write_addr_o,
   output logic [XLEN-1:0]   mem_write_data_o,
   output logic [MEM_AW-1:0] mem_read_addr_o,
   input  logic [XLEN-1:0]   mem_read_data_i
);
   import lsu_pkg::*;
   state_e            state_q, state_d;
   size_e             size_q, size_d;
   logic              we_q, we_d, uns_q, uns_d, err_q, err_d;
   logic [MEM_AW+1:0] addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d, rdata_q, rdata_d, ld_data, merged;
   logic              unused_addr;
   assign unused_addr = ^req_addr_i[31:MEM_AW+2];
   lsu_align u_align (
      .word_i     (mem_read_data_i),
      .wdata_i    (wdata_q),
      .off_i      (addr_q[1:0]),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .rdata_o    (ld_data),
      .merged_o   (merged)
   );
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (req_valid_i) begin
            we_d    = req_we_i;
            size_d  = size_e'(req_size_i);
            uns_d   = req_unsigned_i;
            addr_d  = req_addr_i[MEM_AW+1:0];
            wdata_d = req_wdata_i;
            err_d   = is_misaligned(size_d, req_addr_i[1:0]);
            rdata_d = '0;
            state_d = err_d ? RESP : !req_we_i ? LD_ADDR : (size_d == SZ_W) ? ST_WR : RMW_RD;
         end
         LD_ADDR: state_d = LD_DATA;
         LD_DATA: begin
            rdata_d = ld_data;
            state_d = RESP;
         end
         RMW_RD:        state_d = RMW_WR;
         ST_WR, RMW_WR: state_d = RESP;
         default:       state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= SZ_B;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end
   // Word stores reuse the merge path: a full-word mask passes wdata through untouched.
   assign req_ready_o      = state_q == IDLE;
   assign resp_valid_o     = state_q == RESP;
   assign resp_rdata_o     = rdata_q;
   assign resp_err_o       = err_q;
   assign mem_we_o         = state_q == ST_WR || state_q == RMW_WR;
   assign mem_write_addr_o = addr_q[MEM_AW+1:2];
   assign mem_read_addr_o  = addr_q[MEM_AW+1:2];
   assign mem_write_data_o = merged;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: byte-level reference model and per-cycle compare against lsu_mem_ctrl
module tb_lsu_mem_ctrl;
   localparam int AW = 10;
   logic          clk_i = 0, rst_ni = 0;
   logic          req_valid_i = 0, req_we_i = 0, req_unsigned_i = 0;
   logic [1:0]    req_size_i = 0;
   logic [31:0]   req_addr_i = 0, req_wdata_i = 0;
   logic          req_ready_o, resp_valid_o, resp_err_o, mem_we_o;
   logic [31:0]   resp_rdata_o, mem_write_data_o, mem_read_data_i;
   logic [AW-1:0] mem_write_addr_o, mem_read_addr_o;

   always #5 clk_i = ~clk_i;

   lsu_mem_ctrl #(.MEM_AW(AW), .XLEN(32)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
      .resp_err_o(resp_err_o), .mem_we_o(mem_we_o), .mem_write_addr_o(mem_write_addr_o),
      .mem_write_data_o(mem_write_data_o), .mem_read_addr_o(mem_read_addr_o),
      .mem_read_data_i(mem_read_data_i)
   );

   logic [31:0]   mem [0:1023];
   logic          clr = 0, pl_en = 0;
   logic [AW-1:0] pl_a = 0;
   logic [31:0]   pl_d = 0;
   always @(posedge clk_i) begin
      if (clr) for (int i = 0; i < 1024; i++) mem[i] <= '0;
      else if (pl_en) mem[pl_a] <= pl_d;
      else if (mem_we_o) mem[mem_write_addr_o] <= mem_write_data_o;
      mem_read_data_i <= mem[mem_read_addr_o];
   end

   typedef struct {int due; int e; logic err; logic [31:0] data;} resp_t;
   resp_t         rq[$];
   logic [7:0]    rb [0:4095];
   int            cyc = 0, free_at = 0, n_acc = 0;
   bit            wpend = 0;
   int            wcyc = 0;
   logic [AW-1:0] wadr = 0;
   logic [31:0]   wword = 0;
   int            nchk = 0, nerr = 0, n_resp = 0, we_count = 0, last_lat = 0;
   int            wc, r0, bad;
   logic [31:0]   last_rdata = 0, last_wdata = 0, old;
   logic          last_err = 0;
   logic [AW-1:0] last_waddr = 0;
   bit            exp_rv, exp_we;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      nchk++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [AW-1:0] w);
      return {rb[{w, 2'd3}], rb[{w, 2'd2}], rb[{w, 2'd1}], rb[{w, 2'd0}]};
   endfunction

   task automatic accept();
      int          n   = 1 << req_size_i;
      logic [11:0] b   = req_addr_i[11:0];
      bit          mis = req_size_i == 2'd3 || (req_addr_i % n) != 0;
      int          lat;
      logic [31:0] v   = 0;
      resp_t       r;
      r.e = cyc + 1; r.err = mis; r.data = 0;
      if (mis) lat = 1;
      else if (!req_we_i) begin
         lat = 3;
         for (int i = 0; i < n; i++) v[8*i +: 8] = rb[b + 12'(i)];
         if (!req_unsigned_i && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
         r.data = v;
      end else begin
         lat   = (n == 4) ? 2 : 3;
         wadr  = b[11:2];
         wword = ref_word(wadr);
         for (int i = 0; i < n; i++) wword[8*(int'(b[1:0]) + i) +: 8] = req_wdata_i[8*i +: 8];
         wcyc  = cyc + lat - 1;
         wpend = 1;
      end
      r.due   = cyc + lat;
      free_at = cyc + lat + 1;
      rq.push_back(r);
      n_acc++;
   endtask

   initial forever begin
      @(posedge clk_i);
      if (!rst_ni) begin
         rq.delete(); wpend = 0; free_at = 0;
      end else begin
         if (wpend && wcyc == cyc) begin
            for (int i = 0; i < 4; i++) rb[{wadr, 2'(i)}] = wword[8*i +: 8];
            wpend = 0;
         end
         if (req_valid_i && cyc >= free_at) accept();
      end
      cyc++;
   end

   initial forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
         chk("rst_ready", 32'(req_ready_o), 1);
         chk("rst_resp_valid", 32'(resp_valid_o), 0);
         chk("rst_mem_we", 32'(mem_we_o), 0);
      end else begin
         exp_rv = rq.size() > 0 && rq[0].due == cyc;
         exp_we = wpend && wcyc == cyc;
         chk("ready", 32'(req_ready_o), 32'(cyc >= free_at));
         chk("resp_valid", 32'(resp_valid_o), 32'(exp_rv));
         chk("mem_we", 32'(mem_we_o), 32'(exp_we));
         if (resp_valid_o) begin
            n_resp++; last_rdata = resp_rdata_o; last_err = resp_err_o;
         end
         if (exp_rv) begin
            chk("resp_err", 32'(resp_err_o), 32'(rq[0].err));
            chk("resp_rdata", resp_rdata_o, rq[0].data);
            last_lat = cyc - rq[0].e + 1;
            void'(rq.pop_front());
         end
         if (mem_we_o) begin
            we_count++; last_wdata = mem_write_data_o; last_waddr = mem_write_addr_o;
         end
         if (exp_we) begin
            chk("waddr", 32'(mem_write_addr_o), 32'(wadr));
            chk("wdata", mem_write_data_o, wword);
         end
      end
   end

   task automatic preload(input int w, input logic [31:0] d);
      pl_a = AW'(w); pl_d = d; pl_en = 1;
      @(negedge clk_i);
      pl_en = 0;
      for (int i = 0; i < 4; i++) rb[4*w + i] = d[8*i +: 8];
   endtask

   task automatic txn(input logic we, input logic [1:0] sz, input logic un,
                      input logic [31:0] a, input logic [31:0] wd);
      int q0 = n_resp;
      for (int t = 0; t < 10 && !req_ready_o; t++) @(negedge clk_i);
      req_we_i = we; req_size_i = sz; req_unsigned_i = un; req_addr_i = a; req_wdata_i = wd;
      req_valid_i = 1;
      @(negedge clk_i);
      req_valid_i = 0;
      for (int t = 0; t < 10 && n_resp == q0; t++) @(negedge clk_i);
      chk("resp_seen", 32'(n_resp - q0), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, got no end expected end");
      $fatal(1, "watchdog");
   end

   initial begin
      clr = 1;
      @(negedge clk_i);
      clr = 0;
      for (int i = 0; i < 4096; i++) rb[i] = 0;
      preload(4, 32'h8899aabb);
      chk("rst_rdata", resp_rdata_o, 0);
      chk("rst_err", 32'(resp_err_o), 0);
      chk("rst_raddr", 32'(mem_read_addr_o), 0);
      @(negedge clk_i);
      #2 rst_ni = 1;

      txn(0, 2'd0, 0, 32'h11, 0);
      chk("lb_data", last_rdata, 32'hffffffaa);
      chk("lb_err", 32'(last_err), 0);
      chk("lb_lat", 32'(last_lat), 3);
      txn(0, 2'd0, 1, 32'h11, 0);
      chk("lbu_data", last_rdata, 32'h000000aa);

      wc = we_count;
      txn(1, 2'd2, 0, 32'h20, 32'h12345678);
      chk("sw_waddr", 32'(last_waddr), 8);
      chk("sw_wdata", last_wdata, 32'h12345678);
      chk("sw_we_pulses", 32'(we_count - wc), 1);
      chk("sw_lat", 32'(last_lat), 2);
      txn(0, 2'd2, 0, 32'h20, 0);
      chk("lw_data", last_rdata, 32'h12345678);

      txn(1, 2'd1, 0, 32'h12, 32'h0000cafe);
      chk("sh_wdata", last_wdata, 32'hcafeaabb);
      chk("sh_lat", 32'(last_lat), 3);
      txn(0, 2'd1, 0, 32'h12, 0);
      chk("lh_data", last_rdata, 32'hffffcafe);

      wc = we_count;
      txn(0, 2'd2, 0, 32'h22, 0);
      chk("lw_mis_err", 32'(last_err), 1);
      chk("lw_mis_rdata", last_rdata, 0);
      chk("lw_mis_lat", 32'(last_lat), 1);
      txn(1, 2'd1, 0, 32'h13, 32'hbeef);
      chk("sh_mis_err", 32'(last_err), 1);
      chk("sh_mis_rdata", last_rdata, 0);
      txn(0, 2'd3, 0, 32'h10, 0);
      chk("ill_err", 32'(last_err), 1);
      chk("err_no_we", 32'(we_count - wc), 0);
      txn(0, 2'd2, 0, 32'h10, 0);
      chk("word4_kept", last_rdata, 32'hcafeaabb);
      txn(0, 2'd2, 0, 32'h1020, 0);
      chk("wrap_lw", last_rdata, 32'h12345678);

      for (int k = 0; k < 600; k++) begin
         req_valid_i    = ($urandom_range(0, 4) != 0);
         req_we_i       = 1'($urandom_range(0, 1));
         req_size_i     = 2'($urandom_range(0, 3));
         req_unsigned_i = 1'($urandom_range(0, 1));
         req_addr_i     = 32'($urandom_range(0, 127)) | (($urandom_range(0, 3) == 0) ? ($urandom << 12) : 32'h0);
         req_wdata_i    = $urandom;
         @(negedge clk_i);
      end
      req_valid_i = 0;
      repeat (6) @(negedge clk_i);
      chk("acc_vs_resp", 32'(n_resp), 32'(n_acc));

      old = ref_word(4);
      for (int t = 0; t < 10 && !req_ready_o; t++) @(negedge clk_i);
      req_we_i = 1; req_size_i = 2'd0; req_unsigned_i = 0; req_addr_i = 32'h10; req_wdata_i = 32'h55;
      req_valid_i = 1;
      @(negedge clk_i);
      req_valid_i = 0;
      wc = we_count; r0 = n_resp;
      #2 rst_ni = 0;
      repeat (3) @(negedge clk_i);
      #2 rst_ni = 1;
      @(negedge clk_i);
      chk("rst_ready_after", 32'(req_ready_o), 1);
      chk("rst_no_we", 32'(we_count - wc), 0);
      chk("rst_no_resp", 32'(n_resp - r0), 0);
      chk("rst_mem_word", mem[4], old);
      txn(0, 2'd2, 0, 32'h10, 0);
      chk("rst_lw", last_rdata, old);

      bad = 0;
      for (int w = 0; w < 1024; w++) if (mem[w] !== ref_word(AW'(w))) bad++;
      chk("mem_image", 32'(bad), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store initiator that drives the team's word-aligned, dual-port data memory on behalf of the RV32 core. It accepts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests, converts them to word accesses, and performs read-modify-write for sub-word stores. It returns load data, sign- or zero-extended, and flags misaligned accesses. It sits between the execute stage and the data memory instance.

Parameters:
MEM_AW, 10, word-address width; equals the address-width parameter of the attached memory instance
XLEN, 32, data width; fixed at 32, other values unsupported

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  core request valid
req_ready_o  out  1  block can accept a request
req_we_i  in  1  1 = store, 0 = load
req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned_i  in  1  zero-extend load data (LBU/LHU)
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data, right-aligned
resp_valid_o  out  1  one-cycle response pulse
resp_rdata_o  out  32  extended load data; 0 for stores and errors
resp_err_o  out  1  misaligned or illegal size
mem_we_o  out  1  memory write enable
mem_write_addr_o  out  MEM_AW  word write address
mem_write_data_o  out  32  word write data
mem_read_addr_o  out  MEM_AW  word read address
mem_read_data_i  in  32  memory read data, valid one cycle after the address is presented

Behaviour:
- Reset: state IDLE; resp_valid_o, resp_err_o, resp_rdata_o, mem_we_o = 0; address regs = 0; req_ready_o = 1.
- req_ready_o = (state == IDLE). A transfer occurs when req_valid_i && req_ready_o at a rising edge. At that edge the block latches we, size, unsigned, addr, and wdata.
- Word address = addr[MEM_AW+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^MEM_AW words.
- Misaligned means: half with addr[0]=1, word with addr[1:0]!=0, or size 11. Such a request gets no memory access (mem_we_o stays 0), goes IDLE -> RESP, and the next cycle has resp_valid_o=1, resp_err_o=1, resp_rdata_o=0. Total latency is 1 cycle after accept.
- States: IDLE, LD_ADDR, LD_DATA, ST_WR, RMW_RD, RMW_WR, RESP.
- Load: IDLE -> LD_ADDR (mem_read_addr_o = latched word addr) -> LD_DATA (mem_read_data_i valid).
  - In LD_DATA, select the byte/half by addr[1:0]/addr[1], then extend: sign unless unsigned; word passes through.
  - Register the result into resp_rdata_o, then go -> RESP.
  - resp_valid_o asserts 3 cycles after the accept edge.
- Word store: IDLE -> ST_WR, where mem_we_o=1, mem_write_addr_o = word addr, mem_write_data_o = wdata. Then -> RESP.
- Sub-word store: IDLE -> RMW_RD (read addr presented) -> RMW_WR.
  - In RMW_WR: mem_we_o=1 and mem_write_data_o = mem_read_data_i with the target lane(s) replaced by wdata[7:0] or wdata[15:0], placed by addr[1:0]. Then -> RESP.
  - mem_write_addr_o = mem_read_addr_o = latched word addr.
- RESP: resp_valid_o=1 for exactly one cycle, then -> IDLE. There is no response back-pressure; the core must sink it.
- Outside LD_ADDR, RMW_RD, and RMW_WR, mem_read_addr_o holds the last latched word addr. mem_we_o is 1 only in ST_WR and RMW_WR.
- Throughput:
  - Word store: one per 3 cycles.
  - Load or sub-word store: one per 4 cycles.
  - Error: one per 2 cycles.
  - req_ready_o goes high in the cycle after RESP.
- Reset mid-operation aborts the access immediately. mem_we_o drops asynchronously with rst_ni. An RMW interrupted before the RMW_WR edge leaves memory unchanged, and no response is issued.
- req_valid_i and other inputs are ignored outside IDLE and while rst_ni is low.

Decomposition:
- lsu_pkg:
  - size_e enum (SZ_B, SZ_H, SZ_W, SZ_ILL)
  - state_e enum
  - XLEN constant
  - function is_misaligned(size, addr[1:0])
- Sub-module lsu_align (combinational):
  - load extract/extend: word, addr[1:0], size, unsigned -> rdata
  - store merge: old word, wdata, addr[1:0], size -> new word
- The top module holds only the FSM and registers.

Test Plan:
- Preload word 0x4 = 0x8899AABB. LB addr 0x11 -> resp_rdata_o 0xFFFFFFAA, resp_valid_o 3 cycles after accept, resp_err_o 0. LBU addr 0x11 -> 0x000000AA.
- SW 0x12345678 to addr 0x20 -> mem_we_o one cycle with mem_write_addr_o 8. Then LW 0x20 -> 0x12345678.
- Word 0x4 = 0x8899AABB, SH 0x0000CAFE to addr 0x12 -> write data 0xCAFEAABB. LH 0x12 -> 0xFFFFCAFE.
- LW addr 0x22, SH addr 0x13, size 11 -> each gives resp_err_o=1 and resp_rdata_o=0 one cycle after accept. mem_we_o never asserts and memory is unchanged.
- Back-to-back requests with req_valid_i held high -> accepts only when req_ready_o=1, spaced 3/4 cycles per type, with exactly one resp_valid_o per accept.
- Assert rst_ni low during RMW_RD of SB 0x55 to 0x10 -> mem_we_o stays 0, no response, word unchanged, req_ready_o=1 after release.
